// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU execute stage.
//   add/sub/and/or/slt and srl-by-0 complete on the edge that accepts start.
//   srl by n (1..31) shifts one bit per cycle and completes after n more edges.
//   Undefined op codes complete in one edge with result 0 and err set.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold
// SHIFT  | iterative srl in progress, cnt_q bits still to shift
// DONE   | result valid, done pulse; returns to IDLE next edge
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   start_i       request, sampled only in IDLE
//   alucontrol_i  op code (0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1000 srl)
//   a_i, b_i      operands; srl shifts b_i
//   shamt_i       srl shift amount
//   busy_o        high whenever not IDLE
//   done_o        one-cycle pulse, result valid
//   result_o      registered result, held until the next completion
//   zero_o        result_o == 0
//   err_o         set when the last accepted op code was undefined
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       alucontrol_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       shamt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] shreg_q;
  logic [4:0]       cnt_q;
  logic             err_q;

  logic [WIDTH-1:0] alu_res_d;
  logic             alu_err_d;
  logic             alu_iter_d;
  logic [WIDTH-1:0] shreg_nxt;

  // Single-cycle result computed straight from the inputs in IDLE.
  always_comb begin
    alu_res_d  = '0;
    alu_err_d  = 1'b0;
    alu_iter_d = 1'b0;
    case (alucontrol_i)
      OP_ADD: alu_res_d = a_i + b_i;
      OP_SUB: alu_res_d = a_i - b_i;
      OP_AND: alu_res_d = a_i & b_i;
      OP_OR:  alu_res_d = a_i | b_i;
      OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SRL: begin
        alu_res_d  = b_i;
        alu_iter_d = (shamt_i != 5'd0);
      end
      default: alu_err_d = 1'b1;
    endcase
  end

  assign shreg_nxt = shreg_q >> 1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_q <= alu_err_d;
            if (alu_iter_d) begin
              shreg_q <= b_i;
              cnt_q   <= shamt_i;
              state_q <= S_SHIFT;
            end else begin
              result_q <= alu_res_d;
              state_q  <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          shreg_q <= shreg_nxt;
          cnt_q   <= cnt_q - 5'd1;
          // Last bit: commit the shifted value directly, no extra cycle.
          if (cnt_q == 5'd1) begin
            result_q <= shreg_nxt;
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign zero_o   = (result_q == '0);
  assign err_o    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [3:0]  alucontrol_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  shamt_i;
  logic        busy_o, done_o, zero_o, err_o;
  logic [31:0] result_o;

  always #5 clk_i = ~clk_i;

  seq_alu #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .alucontrol_i(alucontrol_i), .a_i(a_i), .b_i(b_i), .shamt_i(shamt_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .zero_o(zero_o), .err_o(err_o)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int sh);
    exp_t e;
    e.res = 32'h0;
    e.err = 1'b0;
    e.lat = 1;
    case (op)
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: begin
        e.res = b >> sh;
        e.lat = (sh == 0) ? 1 : sh + 1;
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one request, push its expectation, return #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int sh);
    @(negedge clk_i);
    alucontrol_i = op; a_i = a; b_i = b; shamt_i = sh[4:0];
    start_i = 1'b1;
    q.push_back(model(op, a, b, sh));
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    // Inputs are free to change once accepted.
    a_i = $urandom; b_i = $urandom; shamt_i = 5'($urandom);
  endtask

  // n0 = edges already elapsed since the accepting edge at the current sample point.
  task automatic wait_done(input string tag, input int n0);
    exp_t e;
    int n = n0;
    int busy_cnt = 0;
    while (!done_o && n < 40) begin
      if (busy_o) busy_cnt++;
      @(posedge clk_i);
      #1;
      n++;
    end
    if (busy_o) busy_cnt++;
    if (q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
      return;
    end
    e = q.pop_front();
    if (!done_o) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_result"}, result_o, e.res);
    check({tag, "_zero"}, zero_o, (e.res == 32'h0));
    check({tag, "_err"}, err_o, e.err);
    check({tag, "_lat"}, n, e.lat);
    check({tag, "_busy"}, busy_cnt, e.lat - n0 + 1);
    @(posedge clk_i);
    #1;
    check({tag, "_pulse"}, {done_o, busy_o}, 2'b00);
  endtask

  initial begin
    int dcnt;
    rst_ni = 1'b0; start_i = 1'b0; alucontrol_i = 4'h0;
    a_i = 32'h0; b_i = 32'h0; shamt_i = 5'd0;
    #1;
    check("rst_state", {result_o, zero_o, busy_o, done_o, err_o}, {32'h0, 4'b1000});
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Nonzero result, then asynchronous mid-cycle reset.
    issue(4'b0010, 32'd3, 32'd4, 0); wait_done("add_pre", 1);
    @(negedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    check("rst_async", {result_o, zero_o, busy_o, done_o, err_o}, {32'h0, 4'b1000});
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    check("idle_hold", {result_o, zero_o, busy_o, done_o}, {32'h0, 3'b100});

    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 0);   wait_done("add_wrap", 1);
    issue(4'b0110, 32'd5, 32'd5, 0);           wait_done("sub_zero", 1);
    issue(4'b0110, 32'd3, 32'd5, 0);           wait_done("sub_neg", 1);
    issue(4'b0000, 32'hF0F0, 32'hFF00, 0);     wait_done("and", 1);
    issue(4'b0001, 32'hF0F0, 32'hFF00, 0);     wait_done("or", 1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 0);   wait_done("slt_neg", 1);
    issue(4'b0111, 32'h1, 32'hFFFF_FFFF, 0);   wait_done("slt_pos", 1);
    issue(4'b1000, 32'h0, 32'h8000_0000, 31);  wait_done("srl31", 1);
    issue(4'b1000, 32'h0, 32'hDEAD_BEEF, 0);   wait_done("srl0", 1);
    issue(4'b1000, 32'h0, 32'hDEAD_BEEF, 1);   wait_done("srl1", 1);
    issue(4'b1000, 32'h0, 32'hF00D_CAFE, 13);  wait_done("srl13", 1);
    issue(4'b0101, 32'h1, 32'h2, 0);           wait_done("undef", 1);
    issue(4'b0010, 32'h1, 32'h2, 0);           wait_done("err_clear", 1);

    // Start while shifting must be ignored.
    issue(4'b1000, 32'h0, 32'h8000_0000, 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      alucontrol_i = 4'b0010; a_i = 32'd100; b_i = 32'd23; start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
    end
    wait_done("hs_shift", 4);
    check("hs_q_empty", q.size(), 0);
    issue(4'b0010, 32'd100, 32'd23, 0);        wait_done("hs_add", 1);

    // Reset in the middle of a long shift aborts with no done.
    @(negedge clk_i);
    alucontrol_i = 4'b1000; b_i = 32'hFFFF_FFFF; shamt_i = 5'd20; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    check("abort_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("abort_rst", {result_o, zero_o, busy_o, done_o, err_o}, {32'h0, 4'b1000});
    @(negedge clk_i);
    rst_ni = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk_i);
      #1;
      if (done_o || busy_o) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    issue(4'b0010, 32'd40, 32'd2, 0);          wait_done("post_abort", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
